des_sbox_sequencer: RTL

//  Serialised DES S-layer controller. Accepts one 48-bit expanded/keyed word, steps a single shared
//  S-box lookup port through S1..S8 (one 6-bit address per cycle), gathers the 4-bit results and

---
 rtl/des_sbox_sequencer_if.sv | 25 ++
 rtl/des_sbox_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/des_sbox_sequencer_if.sv
// Handshake and S-box lookup bundle for the serialised DES S-layer sequencer.
// The slave modport is the sequencer's view; master is the producer/consumer/ROM side.
interface des_sbox_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        sbox_en;
  logic [2:0]  sbox_sel;
  logic [5:0]  sbox_addr;
  logic [3:0]  sbox_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  modport slave (
    input  in_valid, in_data, sbox_dout, out_ready,
    output in_ready, sbox_en, sbox_sel, sbox_addr, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, sbox_dout, out_ready,
    input  in_ready, sbox_en, sbox_sel, sbox_addr, out_valid, out_data, busy
  );
endinterface

// File: rtl/des_sbox_sequencer.sv
// Serialised DES S-layer: walks one shared S-box port through S1..S8 for a 48-bit word
// and returns the gathered 32-bit result over a valid/ready handshake.
module des_sbox_sequencer #(
  parameter int SBOX_REG = 0
) (
  input logic                 clk,
  input logic                 rst,
  des_sbox_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg;
  logic [47:0] word_reg;
  logic [3:0]  res_reg [8];

  logic [5:0]  chunk [8];
  logic [31:0] out_word;
  logic        in_ready;
  logic        accept;
  logic        cap_en;
  logic [2:0]  cap_slot;

  logic        sbox_en;
  logic [2:0]  sbox_sel;
  logic [5:0]  sbox_addr;
  logic        out_valid;
  logic        busy;

  // chunk k feeds S-box k+1; its 4-bit result lands in nibble k counted from the MSB
  for (genvar gi = 0; gi < 8; gi++) begin : g_slice
    assign chunk[gi]               = word_reg[47-6*gi -: 6];
    assign out_word[31-4*gi -: 4]  = res_reg[gi];
  end

  assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // A registered ROM answers one cycle late, so each capture targets the previous slot
  if (SBOX_REG != 0) begin : g_cap_reg
    assign cap_en   = ((state_reg == ISSUE) && (idx_reg != 3'd0)) || (state_reg == DRAIN);
    assign cap_slot = (state_reg == DRAIN) ? 3'd7 : idx_reg - 3'd1;
  end else begin : g_cap_comb
    assign cap_en   = (state_reg == ISSUE);
    assign cap_slot = idx_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (idx_reg == 3'd7) state_next = (SBOX_REG != 0) ? DRAIN : DONE;
      DRAIN:   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = accept ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sbox_en   = 1'b0;
    sbox_sel  = 3'd0;
    sbox_addr = 6'd0;
    out_valid = (state_reg == DONE);
    busy      = (state_reg != IDLE);
    if (state_reg == ISSUE) begin
      sbox_en   = 1'b1;
      sbox_sel  = idx_reg;
      sbox_addr = chunk[idx_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg  <= 3'd0;
      word_reg <= 48'd0;
      for (int i = 0; i < 8; i++) res_reg[i] <= 4'd0;
    end else if (accept) begin
      idx_reg  <= 3'd0;
      word_reg <= bus.in_data;
      for (int i = 0; i < 8; i++) res_reg[i] <= 4'd0;
    end else begin
      if (state_reg == ISSUE) idx_reg <= idx_reg + 3'd1;
      if (cap_en) res_reg[cap_slot] <= bus.sbox_dout;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sbox_en   = sbox_en;
  assign bus.sbox_sel  = sbox_sel;
  assign bus.sbox_addr = sbox_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_word;
  assign bus.busy      = busy;
endmodule
